ins_unswap: RTL and testbench
=============================

# ins_unswap

Restores original program order of a 4-lane result bundle after execution, undoing the lane permutation applied at issue to steer the load/store instruction onto lane 4. A tag FIFO records each issued bundle's 4-bit swap pattern. Returning result bundles are matched in order, un-permuted, and presented through a registered valid/ready writeback stage. Sits between the execute lanes and register-file writeback.

## Interface
- Clock `clk`; reset `rst`, synchronous, active-high.

Parameters:
- DATA_W, 8, result data width per lane
- DES, 4, destination register index width
- DEPTH, 4, tag FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_vld  in  1  bundle issued this cycle; push swap tag
- issue_swap  in  4  {ins1_swap,ins2_swap,ins3_swap,ins4_swap} applied to that bundle
- issue_rdy  out  1  tag FIFO can accept (not full, not in reset)
- res_vld  in  1  result bundle present, lanes in swapped (execution) order
- res_rdy  out  1  result bundle accepted when res_vld & res_rdy
- res_lane_vld  in  4  per-lane valid, bit i = lane i+1
- res_des  in  4*DES  lane destinations, lane 1 in LSBs
- res_data  in  4*DATA_W  lane data, lane 1 in LSBs
- wb_vld  out  1  restored bundle valid
- wb_rdy  in  1  writeback consumer ready
- wb_lane_vld  out  4  restored per-lane valid
- wb_des  out  4*DES  restored destinations
- wb_data  out  4*DATA_W  restored data
- pending  out  $clog2(DEPTH)+1  tag FIFO occupancy
- unexp_res  out  1  sticky: result arrived with no tag pending

## Operation
- Push: issue_vld & issue_rdy writes issue_swap at write pointer. issue_vld while !issue_rdy is dropped (issuer's violation; no state change).
- res_rdy = (pending != 0) & (!wb_vld | wb_rdy).
- Accept: pop oldest tag, decode, load wb registers with permuted lanes (all fields of a lane move together: vld, des, data).
- Decode (each is an involution, inverse = same swap):
  - 4'b1001: out lane1 ↔ in lane4; lanes 2,3 straight.
  - 4'b1100: lane1 ↔ lane2; lanes 3,4 straight.
  - 4'b1010: lane1 ↔ lane3; lanes 2,4 straight.
  - any other value: identity.
- wb_vld set on accept; cleared when wb_vld & wb_rdy and no new accept that cycle. Accept and drain in same cycle: new bundle replaces old, wb_vld stays 1.
- pending: +1 on push only, -1 on pop only, unchanged on both.
- unexp_res set when res_vld & pending==0; held until rst.

## Timing
- Reset values: wb_vld 0, wb_lane_vld 0, wb_des 0, wb_data 0, pending 0, unexp_res 0, issue_rdy 0 during rst, res_rdy 0; pointers 0.
- issue_rdy = !rst & (pending != DEPTH); combinational from state only.
- Latency: result accepted cycle N → wb_vld/wb data valid cycle N+1.
- Tag pushed cycle N is poppable from cycle N+1 (no bypass); res_vld in cycle N with pending==0 flags unexp_res even if issue_vld also high.
- Full: push blocked even if pop same cycle. Empty: res_rdy 0.
- Pointers wrap modulo DEPTH.
- wb outputs hold stable while wb_vld & !wb_rdy.
- rst mid-operation: all tags and wb contents discarded next edge.
- Throughput: one bundle/cycle with wb_rdy held 1.

## Configuration
- `UNSWAP_ERR_EN` defined: unexp_res tracking compiled in as above.
- Not defined: unexp_res tied to 0; no detect logic; res_vld while empty is simply not accepted.

## Test plan
- Push 4'b1001; result lanes data 0x11,0x22,0x33,0x44, des 1,2,3,4, all valid → next cycle wb_data lanes 0x44,0x22,0x33,0x11, des 4,2,3,1, wb_vld 1.
- Push 1100,1010,0000,1001 (DEPTH=4) → issue_rdy 0, pending 4; fifth push ignored; drain four bundles → each restored with its own tag in order, pending 0.
- Accepted bundle with wb_rdy 0 for 5 cycles → wb outputs unchanged, res_rdy 0; wb_rdy 1 → drains, next bundle accepted same cycle.
- Push 4'b0101, result lanes 0xA,0xB,0xC,0xD with res_lane_vld 4'b0010 → identity: wb_data 0xA,0xB,0xC,0xD, wb_lane_vld 4'b0010.
- res_vld with pending 0 → unexp_res 1 (with UNSWAP_ERR_EN), stays 1 until rst; without macro stays 0.
- pending 3, wb_vld 1, assert rst one cycle → pending 0, wb_vld 0, unexp_res 0, issue_rdy 1 cycle after rst deasserts.

Source files
------------

// File: rtl/ins_unswap.sv
// Result-bundle lane un-permutation with an in-order swap-tag FIFO and a registered writeback stage.
// Optional UNSWAP_ERR_EN: compiles in the sticky unexpected-result detector.
module ins_unswap #(
  parameter int DATA_W = 8,
  parameter int DES    = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_vld,
  input  logic [3:0]               issue_swap,
  output logic                     issue_rdy,
  input  logic                     res_vld,
  output logic                     res_rdy,
  input  logic [3:0]               res_lane_vld,
  input  logic [4*DES-1:0]         res_des,
  input  logic [4*DATA_W-1:0]      res_data,
  output logic                     wb_vld,
  input  logic                     wb_rdy,
  output logic [3:0]               wb_lane_vld,
  output logic [4*DES-1:0]         wb_des,
  output logic [4*DATA_W-1:0]      wb_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     unexp_res
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]          tag_mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic [3:0]          cur_tag;
  logic [1:0]          src [4];
  logic [3:0]          nxt_lane_vld;
  logic [4*DES-1:0]    nxt_des;
  logic [4*DATA_W-1:0] nxt_data;

  assign issue_rdy = !rst && (count != FULL_CNT);
  assign res_rdy   = (count != '0) && (!wb_vld || wb_rdy);
  assign push      = issue_vld && issue_rdy;
  assign pop       = res_vld && res_rdy;
  assign pending   = count;
  assign cur_tag   = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= issue_swap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Every recognised pattern is a single transposition, so the issue-side
  // swap table doubles as its own inverse: src[j] names the input lane for output j.
  always_comb begin
    src[0] = 2'd0;
    src[1] = 2'd1;
    src[2] = 2'd2;
    src[3] = 2'd3;
    case (cur_tag)
      4'b1001: begin src[0] = 2'd3; src[3] = 2'd0; end
      4'b1100: begin src[0] = 2'd1; src[1] = 2'd0; end
      4'b1010: begin src[0] = 2'd2; src[2] = 2'd0; end
      default: ;
    endcase
  end

  always_comb begin
    nxt_lane_vld = '0;
    nxt_des      = '0;
    nxt_data     = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      nxt_lane_vld[j]                = res_lane_vld[src[j]];
      nxt_des[j*DES +: DES]          = res_des[src[j]*DES +: DES];
      nxt_data[j*DATA_W +: DATA_W]   = res_data[src[j]*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld      <= 1'b0;
      wb_lane_vld <= '0;
      wb_des      <= '0;
      wb_data     <= '0;
    end else if (pop) begin
      wb_vld      <= 1'b1;
      wb_lane_vld <= nxt_lane_vld;
      wb_des      <= nxt_des;
      wb_data     <= nxt_data;
    end else if (wb_rdy) begin
      wb_vld      <= 1'b0;
    end
  end

`ifdef UNSWAP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      unexp_res <= 1'b0;
    end else if (res_vld && (count == '0)) begin
      unexp_res <= 1'b1;
    end
  end
`else
  assign unexp_res = 1'b0;
`endif

endmodule

// File: tb/tb_ins_unswap.sv
// Directed self-checking bench for ins_unswap (default parameters).
module tb_ins_unswap;

  localparam int DATA_W = 8;
  localparam int DES    = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_vld;
  logic [3:0]  issue_swap;
  logic        issue_rdy;
  logic        res_vld;
  logic        res_rdy;
  logic [3:0]  res_lane_vld;
  logic [15:0] res_des;
  logic [31:0] res_data;
  logic        wb_vld;
  logic        wb_rdy;
  logic [3:0]  wb_lane_vld;
  logic [15:0] wb_des;
  logic [31:0] wb_data;
  logic [2:0]  pending;
  logic        unexp_res;

  int checks   = 0;
  int failures = 0;

`ifdef UNSWAP_ERR_EN
  localparam logic UNEXP_EXP = 1'b1;
`else
  localparam logic UNEXP_EXP = 1'b0;
`endif

  ins_unswap #(.DATA_W(DATA_W), .DES(DES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_swap(issue_swap), .issue_rdy(issue_rdy),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_lane_vld(res_lane_vld),
    .res_des(res_des), .res_data(res_data),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_lane_vld(wb_lane_vld),
    .wb_des(wb_des), .wb_data(wb_data),
    .pending(pending), .unexp_res(unexp_res)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; issue_vld = 1'b0; issue_swap = '0; res_vld = 1'b0;
    res_lane_vld = '0; res_des = '0; res_data = '0; wb_rdy = 1'b1;
    step(); step();
    checks++; if (issue_rdy !== 1'b0) begin failures++; $display("FAIL rst_issue_rdy got=%b exp=0", issue_rdy); end
    checks++; if (wb_vld !== 1'b0) begin failures++; $display("FAIL rst_wb_vld got=%b exp=0", wb_vld); end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL rst_pending got=%0d exp=0", pending); end
    checks++; if (res_rdy !== 1'b0) begin failures++; $display("FAIL rst_res_rdy got=%b exp=0", res_rdy); end
    checks++; if (wb_data !== 32'h0 || wb_des !== 16'h0 || wb_lane_vld !== 4'h0) begin failures++;
      $display("FAIL rst_wb_fields got=%h/%h/%h exp=0/0/0", wb_data, wb_des, wb_lane_vld); end
    checks++; if (unexp_res !== 1'b0) begin failures++; $display("FAIL rst_unexp got=%b exp=0", unexp_res); end
    rst = 1'b0;
    #1;
    checks++; if (issue_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_issue_rdy got=%b exp=1", issue_rdy); end
  endtask

  task automatic test_swap_1001;
    issue_vld = 1'b1; issue_swap = 4'b1001;
    step();
    issue_vld = 1'b0;
    checks++; if (pending !== 3'd1 || res_rdy !== 1'b1) begin failures++;
      $display("FAIL s1001_pending got=%0d rdy=%b exp=1 rdy=1", pending, res_rdy); end
    res_vld = 1'b1; res_lane_vld = 4'b1111;
    res_data = 32'h44332211; res_des = 16'h4321;
    step();
    res_vld = 1'b0;
    checks++; if (wb_vld !== 1'b1 || wb_data !== 32'h11332244) begin failures++;
      $display("FAIL s1001_data got=%b/%h exp=1/11332244", wb_vld, wb_data); end
    checks++; if (wb_des !== 16'h1324 || wb_lane_vld !== 4'b1111) begin failures++;
      $display("FAIL s1001_des got=%h/%b exp=1324/1111", wb_des, wb_lane_vld); end
    step();
    checks++; if (wb_vld !== 1'b0 || pending !== 3'd0) begin failures++;
      $display("FAIL s1001_drain got=%b/%0d exp=0/0", wb_vld, pending); end
  endtask

  task automatic test_full;
    logic [3:0]  tags [4];
    logic [31:0] exp_data [4];
    tags[0] = 4'b1100; tags[1] = 4'b1010; tags[2] = 4'b0000; tags[3] = 4'b1001;
    exp_data[0] = 32'h44331122; exp_data[1] = 32'h44112233;
    exp_data[2] = 32'h44332211; exp_data[3] = 32'h11332244;
    for (int i = 0; i < 4; i++) begin
      issue_vld = 1'b1; issue_swap = tags[i];
      step();
    end
    checks++; if (pending !== 3'd4 || issue_rdy !== 1'b0) begin failures++;
      $display("FAIL full_state got=%0d/%b exp=4/0", pending, issue_rdy); end
    issue_swap = 4'b0110;
    step();
    checks++; if (pending !== 3'd4) begin failures++; $display("FAIL full_drop got=%0d exp=4", pending); end
    res_vld = 1'b1; res_lane_vld = 4'b1111;
    res_data = 32'h44332211; res_des = 16'h4321;
    for (int i = 0; i < 4; i++) begin
      issue_vld = (i == 0);
      step();
      checks++; if (wb_vld !== 1'b1 || wb_data !== exp_data[i]) begin failures++;
        $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, wb_vld, wb_data, exp_data[i]); end
      if (i == 0) begin
        checks++; if (pending !== 3'd3) begin failures++; $display("FAIL full_push_pop got=%0d exp=3", pending); end
      end
    end
    res_vld = 1'b0; issue_vld = 1'b0;
    checks++; if (pending !== 3'd0 || res_rdy !== 1'b0) begin failures++;
      $display("FAIL full_empty got=%0d/%b exp=0/0", pending, res_rdy); end
    step();
  endtask

  task automatic test_back_to_back;
    wb_rdy = 1'b0;
    issue_vld = 1'b1; issue_swap = 4'b1001; step();
    issue_swap = 4'b0000; step();
    issue_vld = 1'b0;
    res_vld = 1'b1; res_lane_vld = 4'b1111; res_data = 32'h44332211; res_des = 16'h4321;
    step();
    res_data = 32'h88776655; res_des = 16'h8765; res_lane_vld = 4'b0111;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (wb_vld !== 1'b1 || wb_data !== 32'h11332244 || wb_des !== 16'h1324 || res_rdy !== 1'b0) begin failures++;
        $display("FAIL bp_hold%0d got=%b/%h/%h rdy=%b exp=1/11332244/1324 rdy=0", i, wb_vld, wb_data, wb_des, res_rdy); end
      step();
    end
    checks++; if (pending !== 3'd1) begin failures++; $display("FAIL bp_pending got=%0d exp=1", pending); end
    wb_rdy = 1'b1;
    #1;
    checks++; if (res_rdy !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", res_rdy); end
    step();
    res_vld = 1'b0;
    checks++; if (wb_vld !== 1'b1 || wb_data !== 32'h88776655 || wb_lane_vld !== 4'b0111 || pending !== 3'd0) begin failures++;
      $display("FAIL bp_next got=%b/%h/%b/%0d exp=1/88776655/0111/0", wb_vld, wb_data, wb_lane_vld, pending); end
    step();
  endtask

  task automatic test_identity;
    issue_vld = 1'b1; issue_swap = 4'b0101; step();
    issue_vld = 1'b0;
    res_vld = 1'b1; res_lane_vld = 4'b0010; res_data = 32'h0D0C0B0A; res_des = 16'h9ABC;
    step();
    res_vld = 1'b0;
    checks++; if (wb_data !== 32'h0D0C0B0A || wb_lane_vld !== 4'b0010 || wb_des !== 16'h9ABC) begin failures++;
      $display("FAIL ident got=%h/%b/%h exp=0d0c0b0a/0010/9abc", wb_data, wb_lane_vld, wb_des); end
    step();
  endtask

  task automatic test_unexp;
    checks++; if (unexp_res !== 1'b0) begin failures++; $display("FAIL unexp_pre got=%b exp=0", unexp_res); end
    issue_vld = 1'b1; issue_swap = 4'b0000; res_vld = 1'b1; res_data = 32'hDEADBEEF;
    step();
    issue_vld = 1'b0; res_vld = 1'b0;
    checks++; if (unexp_res !== UNEXP_EXP || wb_vld !== 1'b0 || pending !== 3'd1) begin failures++;
      $display("FAIL unexp_set got=%b/%b/%0d exp=%b/0/1", unexp_res, wb_vld, pending, UNEXP_EXP); end
    res_vld = 1'b1; step();
    res_vld = 1'b0; step(); step();
    checks++; if (unexp_res !== UNEXP_EXP || pending !== 3'd0) begin failures++;
      $display("FAIL unexp_sticky got=%b/%0d exp=%b/0", unexp_res, pending, UNEXP_EXP); end
  endtask

  task automatic test_reset_mid;
    wb_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_vld = 1'b1; issue_swap = 4'b1100; step();
    end
    issue_vld = 1'b0;
    res_vld = 1'b1; res_data = 32'h44332211; step();
    res_vld = 1'b0;
    checks++; if (pending !== 3'd3 || wb_vld !== 1'b1) begin failures++;
      $display("FAIL mid_pre got=%0d/%b exp=3/1", pending, wb_vld); end
    rst = 1'b1;
    #1;
    checks++; if (issue_rdy !== 1'b0) begin failures++; $display("FAIL mid_rdy_in_rst got=%b exp=0", issue_rdy); end
    step();
    rst = 1'b0; wb_rdy = 1'b1;
    #1;
    checks++; if (pending !== 3'd0 || wb_vld !== 1'b0 || unexp_res !== 1'b0 || issue_rdy !== 1'b1 || wb_data !== 32'h0) begin failures++;
      $display("FAIL mid_post got=%0d/%b/%b/%b/%h exp=0/0/0/1/0", pending, wb_vld, unexp_res, issue_rdy, wb_data); end
  endtask

  initial begin
    test_reset();
    test_swap_1001();
    test_full();
    test_back_to_back();
    test_identity();
    test_unexp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
